adc_ecc_sequencer: RTL
======================

Name: adc_ecc_sequencer

Overview:
Clocked controller that sequences one flash-ADC conversion through the Hamming protect/check path: samples the 3-bit ADC code, drives the external Hamming encoder, optionally corrupts the codeword, drives the external error-correction block, and presents the checked result on a valid/ready output. Sits between the combinational flash_adc / hamming_code_encoder / hamming_error_correction instances and the downstream consumer. Keeps saturating frame and corrected-error counters.

Parameters:
SETTLE_CYC, 1, cycles (>=1) the encoder and corrector outputs are given to settle before capture
CNT_W, 8, width of frame_count and corr_count

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request one conversion; accepted only in IDLE
adc_code  in  3  flash ADC binary output
parity_type  in  1  0 even, 1 odd; latched at accept, driven to encoder/corrector
enc_data  out  4  encoder data_in, {1'b0, sampled code}
enc_code  in  7  encoder code_out
chan_code  out  7  corrector code_in (clean or injected codeword)
corr_code  in  7  corrector data_out
par_type_q  out  1  latched parity_type to both Hamming blocks
inject_pos  in  3  bit position 1..7 to flip; 0 = none (used only with ADC_SEQ_INJECT_EN)
busy  out  1  high in any state except IDLE
out_valid  out  1  result valid
out_ready  in  1  consumer ready
out_code  out  7  captured corrected codeword
out_corrected  out  1  corr_code differed from chan_code
out_fail  out  1  corr_code differed from clean enc_code
clear_cnt  in  1  synchronous clear of both counters
frame_count  out  CNT_W  completed frames, saturating
corr_count  out  CNT_W  frames with out_corrected=1, saturating

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, out_valid, out_corrected, out_fail=0; out_code, enc_data, chan_code, counters=0; par_type_q=0.
- States: IDLE -> SAMPLE -> ENCODE -> CHECK -> OUTPUT -> IDLE.
- IDLE: start=1 at edge k -> SAMPLE; latch parity_type into par_type_q.
- SAMPLE (1 cycle): latch adc_code; enc_data <= {1'b0, adc_code}.
- ENCODE (SETTLE_CYC cycles, internal counter): on last cycle latch enc_code as clean_q, load chan_code <= enc_code ^ inject mask.
- CHECK (SETTLE_CYC cycles): on last cycle capture corr_code into out_code; out_corrected = (corr_code != chan_code); out_fail = (corr_code != clean_q).
- OUTPUT: out_valid=1; out_code/flags held stable until out_valid & out_ready; on handshake -> IDLE, out_valid=0, frame_count+1, corr_count+1 if out_corrected.
- Latency: start accepted at edge k -> out_valid high from edge k+2+2*SETTLE_CYC (k+4 at default).
- start outside IDLE ignored, not queued. start in the handshake cycle ignored; next start accepted in IDLE.
- Counters saturate at all-ones. clear_cnt and increment same cycle: clear wins, result 0.
- adc_code / parity_type changes after acceptance have no effect on the in-flight frame.
- Reset mid-frame aborts immediately; no partial count update.

Optional Feature:
ADC_SEQ_INJECT_EN: defined -> mask = one-hot at inject_pos (sampled in SAMPLE); 0 means no flip. Undefined -> mask = 0, inject_pos ignored, chan_code always equals clean_q, out_corrected from single-bit injection never possible.

Decomposition:
- Package adc_ecc_pkg: state enum, ADC_W=3, DATA_W=4, CODE_W=7, inject-mask function (pos -> one-hot 7-bit).
- Sub-module adc_ecc_sat_counter (CNT_W, inc, clr) instantiated twice for frame_count and corr_count.

Test Plan:
- Reset mid-CHECK (rst_n low 1 cycle) -> busy=0, out_valid=0, counters unchanged at 0, next start works normally.
- adc_code=3'b101, parity_type=0, no injection, start pulse -> out_valid at k+4, out_code=clean enc_code, out_corrected=0, out_fail=0, frame_count=1.
- With ADC_SEQ_INJECT_EN, inject_pos=3 -> chan_code differs from clean in bit 3, out_corrected=1, out_fail=0, corr_count=1.
- out_ready held low 10 cycles -> out_valid and out_code stable; start pulses ignored; frame_count increments once on release.
- CNT_W=2, 5 frames -> frame_count saturates at 3; clear_cnt coincident with a handshake -> 0.
- SETTLE_CYC=3 -> out_valid at k+8; parity_type toggled after acceptance has no effect on par_type_q.

Source files
------------

// File: rtl/adc_ecc_pkg.sv
// Shared types and helpers for the ADC-to-Hamming conversion sequencer.
package adc_ecc_pkg;

    localparam int ADC_W  = 3;
    localparam int DATA_W = 4;
    localparam int CODE_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_ENCODE,
        ST_CHECK,
        ST_OUTPUT
    } seq_state_t;

    // Codeword positions are numbered 1..7, so position p maps to bit p-1; 0 selects no flip.
    function automatic logic [CODE_W-1:0] inject_mask(input logic [2:0] pos);
        logic [CODE_W-1:0] mask;
        mask = '0;
        if (pos != 3'd0) begin
            mask[pos - 3'd1] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/adc_ecc_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module adc_ecc_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_ecc_sequencer.sv
// Sequences one flash-ADC sample through the external Hamming encoder and corrector.
// Optional codeword fault injection is enabled by defining ADC_SEQ_INJECT_EN.
module adc_ecc_sequencer
    import adc_ecc_pkg::*;
#(
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADC_W-1:0]  adc_code,
    input  logic              parity_type,
    output logic [DATA_W-1:0] enc_data,
    input  logic [CODE_W-1:0] enc_code,
    output logic [CODE_W-1:0] chan_code,
    input  logic [CODE_W-1:0] corr_code,
    output logic              par_type_q,
    input  logic [2:0]        inject_pos,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_corrected,
    output logic              out_fail,
    input  logic              clear_cnt,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  corr_count
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    seq_state_t        state;
    seq_state_t        state_next;
    logic [SET_W-1:0]  settle_cnt;
    logic              settle_last;
    logic              handshake;
    logic [CODE_W-1:0] clean_q;
    logic [CODE_W-1:0] chan_mask;

    assign settle_last = (settle_cnt == SET_W'(SETTLE_CYC - 1));

`ifdef ADC_SEQ_INJECT_EN
    logic [2:0] inject_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inject_q <= 3'd0;
        end else if (state == ST_SAMPLE) begin
            inject_q <= inject_pos;
        end
    end

    assign chan_mask = inject_mask(inject_q);
`else
    logic inject_unused;

    assign inject_unused = ^inject_pos;
    assign chan_mask     = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = ST_ENCODE;
            ST_ENCODE: if (settle_last) state_next = ST_CHECK;
            ST_CHECK:  if (settle_last) state_next = ST_OUTPUT;
            ST_OUTPUT: if (handshake) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        handshake = (state == ST_OUTPUT) && out_valid && out_ready;
    end

    // One counter serves both settle windows; it idles at zero between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (((state == ST_ENCODE) || (state == ST_CHECK)) && !settle_last) begin
            settle_cnt <= settle_cnt + SET_W'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    // out_valid is a flop that rises the cycle after OUTPUT is entered, so the result
    // registers captured at the end of CHECK are already stable when it asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_type_q    <= 1'b0;
            enc_data      <= '0;
            clean_q       <= '0;
            chan_code     <= '0;
            out_code      <= '0;
            out_corrected <= 1'b0;
            out_fail      <= 1'b0;
            out_valid     <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                par_type_q <= parity_type;
            end
            if (state == ST_SAMPLE) begin
                enc_data <= {1'b0, adc_code};
            end
            if ((state == ST_ENCODE) && settle_last) begin
                clean_q   <= enc_code;
                chan_code <= enc_code ^ chan_mask;
            end
            if ((state == ST_CHECK) && settle_last) begin
                out_code      <= corr_code;
                out_corrected <= (corr_code != chan_code);
                out_fail      <= (corr_code != clean_q);
            end
            if (handshake) begin
                out_valid <= 1'b0;
            end else if (state == ST_OUTPUT) begin
                out_valid <= 1'b1;
            end
        end
    end

    adc_ecc_sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (handshake),
        .clr   (clear_cnt),
        .count (frame_count)
    );

    adc_ecc_sat_counter #(.CNT_W(CNT_W)) u_corr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (handshake && out_corrected),
        .clr   (clear_cnt),
        .count (corr_count)
    );

endmodule
